// File: rtl/xif_copro_result_buf.sv
// rtl/xif_copro_result_buf.sv - in-order result FIFO between the coprocessor ex stage and the XIF result channel
// Optional feature macro: XIF_COPRO_RESULT_BYPASS_EN (zero-latency bypass while the buffer is empty).
// The default build leaves the macro undefined and has a minimum latency of one cycle.
module xif_copro_result_buf #(
    parameter int  XLEN  = 64,
    parameter int  DEPTH = 4,
    parameter type tag_t = logic
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  tag_t                       in_tag_i,
    input  logic [XLEN-1:0]            in_result_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output tag_t                       tag_o,
    output logic [XLEN-1:0]            result_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        tag_t            tag;
        logic [XLEN-1:0] data;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic buf_empty;
    logic push;
    logic pop;
    logic bypass_take;
    logic store;
    logic deq;

    assign buf_empty  = (count_q == '0);
    // Ready depends only on occupancy so the core's ready never reaches the ex stage combinationally.
    assign in_ready_o = (count_q != CW'(DEPTH));
    assign count_o    = count_q;

`ifdef XIF_COPRO_RESULT_BYPASS_EN
    // While empty, the incoming entry is shown directly to the core.
    assign result_valid_o = buf_empty ? in_valid_i  : 1'b1;
    assign tag_o          = buf_empty ? in_tag_i    : mem_q[rd_ptr_q].tag;
    assign result_o       = buf_empty ? in_result_i : mem_q[rd_ptr_q].data;
    assign bypass_take    = buf_empty & in_valid_i & result_ready_i;
`else
    assign result_valid_o = !buf_empty;
    assign tag_o          = buf_empty ? tag_t'('0)  : mem_q[rd_ptr_q].tag;
    assign result_o       = buf_empty ? '0          : mem_q[rd_ptr_q].data;
    assign bypass_take    = 1'b0;
`endif

    assign push  = in_valid_i & in_ready_o;
    assign pop   = result_valid_o & result_ready_i;
    // A bypassed entry is consumed in flight and never touches the array or the pointers.
    assign store = push & ~bypass_take;
    assign deq   = pop & ~bypass_take;

    // Next-state: flush clears occupancy and discards the handshakes of its own cycle.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (store) begin
                mem_d[wr_ptr_q] = '{tag: in_tag_i, data: in_result_i};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (deq) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(store) - CW'(deq);
        end
    end

    // State registers; reset clears control state only, array contents are don't-care.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
